prc1chan_p: RTL and testbench

Parametrised single-channel processor, successor to the fixed 12-bit channel block. It subtracts the pedestal, generates a prescaled self trigger, and captures windows on master or self trigger into an output FIFO read by the channel arbiter. Master blocks are zero-suppressed. New in this generation:
- ADC width and buffer depths are parameters.
- The pedestal excludes signal samples.
- The block has a synchronous reset.
- Blocks that do not fit in the FIFO are dropped and counted, never written partially.

---
 rtl/prc1chan_pkg.sv | 23 ++
 rtl/prc1chan_fifo.sv | 45 ++++
 rtl/prc1chan_p.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_prc1chan_p.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/prc1chan_pkg.sv
// Shared definitions for the single-channel processor: one-hot FSM encoding,
// block signatures and the output FIFO free-space calculation.
package prc1chan_pkg;

  localparam logic [4:0] S_IDLE   = 5'b00001;
  localparam logic [4:0] S_STCOPY = 5'b00010;
  localparam logic [4:0] S_MTRIG  = 5'b00100;
  localparam logic [4:0] S_MTNUM  = 5'b01000;
  localparam logic [4:0] S_MTCOPY = 5'b10000;

  localparam logic [1:0] SIG_SELF   = 2'b10;
  localparam logic [1:0] SIG_MASTER = 2'b11;

  // One slot is kept empty so that a full FIFO is distinguishable from an empty one.
  function automatic int unsigned free_space(input int unsigned start,
                                             input int unsigned rd,
                                             input int unsigned fbits);
    int unsigned mask;
    mask = (32'd1 << fbits) - 32'd1;
    return mask - ((start - rd) & mask);
  endfunction

endpackage

// File: rtl/prc1chan_fifo.sv
// Output FIFO with separate write and commit pointers. Words written after the
// last commit stay invisible to the reader and can be dropped by a rewind.
// The head word falls through to dout whenever a committed word is present.
module prc1chan_fifo #(
  parameter int FBITS = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [15:0]      wdata,
  input  logic             commit,
  input  logic             rewind,
  input  logic             ack,
  output logic [15:0]      dout,
  output logic             req,
  output logic [FBITS-1:0] cptr,
  output logic [FBITS-1:0] rptr
);

  logic [15:0]      mem [0:(1<<FBITS)-1];
  logic [FBITS-1:0] wptr;

  // storage array, no reset needed since only committed words are ever shown
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= wdata;
  end

  // write, commit and read pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      cptr <= '0;
      rptr <= '0;
    end else begin
      if (rewind)  wptr <= cptr;
      else if (wr) wptr <= wptr + 1'b1;
      if (commit)  cptr <= wr ? wptr + 1'b1 : wptr;
      if (req && ack) rptr <= rptr + 1'b1;
    end
  end

  assign req  = (rptr != cptr);
  assign dout = req ? mem[rptr] : 16'h0000;

endmodule

// File: rtl/prc1chan_p.sv
// Single-channel processor: pedestal subtraction, prescaled self trigger and
// windowed capture into a commit/rewind output FIFO.
// Optional feature macro: PRC1CHAN_SELFTRIG_EN (self trigger, STCOPY state and
// the threshold-based pedestal exclusion). Without it every sample feeds the
// pedestal and only master triggers capture blocks.
module prc1chan_p
  import prc1chan_pkg::*;
#(
  parameter int ABITS = 12,
  parameter int PBITS = 10,
  parameter int CBITS = 10,
  parameter int FBITS = 11,
  parameter int NBITS = 6,
  parameter int LBITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ABITS-1:0] data,
  input  logic [ABITS-1:0] cped,
  input  logic [ABITS-1:0] zthr,
  input  logic [ABITS-1:0] sthr,
  input  logic [15:0]      prescale,
  input  logic [CBITS-1:0] winbeg,
  input  logic [CBITS-1:0] swinbeg,
  input  logic [LBITS-1:0] winlen,
  input  logic [15:0]      trigger,
  input  logic [NBITS-1:0] num,
  input  logic             smask,
  input  logic             tmask,
  input  logic             stmask,
  output logic [ABITS-1:0] d2sum,
  output logic [ABITS-1:0] ped,
  output logic [15:0]      dout,
  output logic             req,
  input  logic             ack,
  output logic [15:0]      ovf_cnt
);

  // State table
  //   state    | meaning
  //   S_IDLE   | waiting for master trigger or self trigger
  //   S_STCOPY | self block header written, copying window
  //   S_MTRIG  | writing master header, loading read address
  //   S_MTNUM  | writing the master trigger word
  //   S_MTCOPY | copying master window, zero-suppressed at the end

  if (NBITS + LBITS != 14) begin : g_bad_fields
    $error("NBITS+LBITS must equal 14");
  end

  logic [ABITS-1:0]       pdata, data_d, rdata;
  logic                   pvld;
  logic [ABITS+1:0]       pcalc;
  logic [ABITS:0]         dcalc, zlim;
  logic [ABITS+PBITS-1:0] acc, acc_next;
  logic [PBITS-1:0]       pcount;
  logic                   take;
  logic [ABITS-1:0]       cbuf [0:(1<<CBITS)-1];
  logic [CBITS-1:0]       waddr, raddr;
  logic [4:0]             state;
  logic [LBITS-1:0]       wl, icnt, wcnt;
  logic                   rvld, hit, mtrig, room;
  logic [15:0]            trig_q, sample, fwdata;
  logic                   fwr, fcommit, frewind;
  logic [FBITS-1:0]       cptr, rptr;

  assign pcalc    = {2'b00, data} + {2'b00, cped} - {2'b00, ped};
  assign dcalc    = {1'b0, data} - {1'b0, ped};
  assign zlim     = {1'b0, zthr} + {1'b0, cped};
  assign acc_next = acc + {{PBITS{1'b0}}, data_d};
  assign sample   = {{(16-ABITS){1'b0}}, rdata};
  assign mtrig    = trigger[15] && !tmask;
  assign room     = free_space(32'(cptr), 32'(rptr), FBITS) >= (32'(winlen) + 32'd2);

`ifdef PRC1CHAN_SELFTRIG_EN
  logic [ABITS:0] slim;
  logic           armed, cross, strig;
  logic [15:0]    pscnt;

  assign slim  = {1'b0, sthr} + {1'b0, cped};
  assign take  = pvld && ({1'b0, pdata} <= slim);
  assign cross = armed && ({1'b0, pdata} > slim);
  assign strig = cross && (pscnt >= prescale) && !stmask;

  // crossing detector with re-arm hysteresis and prescale counter
  always_ff @(posedge clk) begin
    if (reset) begin
      armed <= 1'b1;
      pscnt <= '0;
    end else if (cross) begin
      armed <= 1'b0;
      pscnt <= (pscnt >= prescale) ? 16'd0 : pscnt + 16'd1;
    end else if ({1'b0, pdata} < slim) begin
      armed <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{sthr, swinbeg, prescale, stmask};
  assign take = pvld;
`endif

  // front end: offset-corrected sample, sum output, pedestal averaging
  always_ff @(posedge clk) begin
    if (reset) begin
      pvld   <= 1'b0;
      pdata  <= '0;
      data_d <= '0;
      d2sum  <= '0;
      ped    <= '0;
      acc    <= '0;
      pcount <= '0;
    end else begin
      pvld   <= 1'b1;
      data_d <= data;
      if (pcalc[ABITS+1])   pdata <= '0;
      else if (pcalc[ABITS]) pdata <= '1;
      else                  pdata <= pcalc[ABITS-1:0];
      d2sum <= (smask || dcalc[ABITS]) ? '0 : dcalc[ABITS-1:0];
      if (take) begin
        if (pcount == '1) begin
          ped    <= acc_next[ABITS+PBITS-1:PBITS];
          acc    <= '0;
          pcount <= '0;
        end else begin
          acc    <= acc_next;
          pcount <= pcount + 1'b1;
        end
      end
    end
  end

  // circular sample buffer, written every cycle, registered read
  always_ff @(posedge clk) begin
    cbuf[waddr] <= pdata;
    rdata       <= cbuf[raddr];
  end

  // FIFO write/commit/rewind decode
  always_comb begin
    fwr     = 1'b0;
    fwdata  = 16'h0000;
    fcommit = 1'b0;
    frewind = 1'b0;
    case (state)
      S_IDLE: begin
`ifdef PRC1CHAN_SELFTRIG_EN
        if (!mtrig && strig && room) begin
          fwr    = 1'b1;
          fwdata = {SIG_SELF, num, winlen};
        end
`endif
      end
`ifdef PRC1CHAN_SELFTRIG_EN
      S_STCOPY: begin
        if (mtrig)            frewind = 1'b1;
        else if (wcnt == wl)  fcommit = 1'b1;
        else if (rvld) begin
          fwr    = 1'b1;
          fwdata = sample;
        end
      end
`endif
      S_MTRIG: begin
        fwr    = 1'b1;
        fwdata = {SIG_MASTER, num, wl};
      end
      S_MTNUM: begin
        fwr    = 1'b1;
        fwdata = trig_q;
      end
      S_MTCOPY: begin
        if (wcnt == wl) begin
          fcommit = hit;
          frewind = !hit;
        end else if (rvld) begin
          fwr    = 1'b1;
          fwdata = sample;
        end
      end
      default: ;
    endcase
  end

  // capture FSM, window read sequencing and overflow counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      waddr   <= '0;
      raddr   <= '0;
      wl      <= '0;
      icnt    <= '0;
      wcnt    <= '0;
      rvld    <= 1'b0;
      hit     <= 1'b0;
      trig_q  <= '0;
      ovf_cnt <= '0;
    end else begin
      waddr <= waddr + 1'b1;
      rvld  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mtrig) begin
            if (room) begin
              state  <= S_MTRIG;
              trig_q <= trigger;
              wl     <= winlen;
            end else if (ovf_cnt != 16'hFFFF) begin
              ovf_cnt <= ovf_cnt + 16'd1;
            end
`ifdef PRC1CHAN_SELFTRIG_EN
          end else if (strig) begin
            if (room) begin
              state <= S_STCOPY;
              wl    <= winlen;
              raddr <= waddr - swinbeg;
              icnt  <= '0;
              wcnt  <= '0;
            end else if (ovf_cnt != 16'hFFFF) begin
              ovf_cnt <= ovf_cnt + 16'd1;
            end
`endif
          end
        end
`ifdef PRC1CHAN_SELFTRIG_EN
        S_STCOPY: begin
          if (mtrig) begin
            if (room) begin
              state  <= S_MTRIG;
              trig_q <= trigger;
              wl     <= winlen;
            end else begin
              state <= S_IDLE;
              if (ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
            end
          end else if (wcnt == wl) begin
            state <= S_IDLE;
          end else begin
            if (icnt != wl) begin
              raddr <= raddr + 1'b1;
              icnt  <= icnt + 1'b1;
              rvld  <= 1'b1;
            end
            if (rvld) wcnt <= wcnt + 1'b1;
          end
        end
`endif
        S_MTRIG: begin
          raddr <= waddr - winbeg;
          icnt  <= '0;
          wcnt  <= '0;
          hit   <= 1'b0;
          state <= S_MTNUM;
        end
        S_MTNUM: begin
          if (icnt != wl) begin
            raddr <= raddr + 1'b1;
            icnt  <= icnt + 1'b1;
            rvld  <= 1'b1;
          end
          state <= S_MTCOPY;
        end
        S_MTCOPY: begin
          if (wcnt == wl) begin
            state <= S_IDLE;
          end else begin
            if (icnt != wl) begin
              raddr <= raddr + 1'b1;
              icnt  <= icnt + 1'b1;
              rvld  <= 1'b1;
            end
            if (rvld) begin
              wcnt <= wcnt + 1'b1;
              if ({1'b0, rdata} > zlim) hit <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  prc1chan_fifo #(.FBITS(FBITS)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr     (fwr),
    .wdata  (fwdata),
    .commit (fcommit),
    .rewind (frewind),
    .ack    (ack),
    .dout   (dout),
    .req    (req),
    .cptr   (cptr),
    .rptr   (rptr)
  );

endmodule

// File: tb/tb_prc1chan_p.sv
// Directed bench for prc1chan_p with small pedestal, buffer and FIFO sizes.
module tb_prc1chan_p;

  localparam int ABITS = 12;
  localparam int PBITS = 4;
  localparam int CBITS = 6;
  localparam int FBITS = 6;
  localparam int NBITS = 6;
  localparam int LBITS = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [ABITS-1:0] data, cped, zthr, sthr;
  logic [15:0]      prescale;
  logic [CBITS-1:0] winbeg, swinbeg;
  logic [LBITS-1:0] winlen;
  logic [15:0]      trigger;
  logic [NBITS-1:0] num;
  logic             smask, tmask, stmask;
  logic [ABITS-1:0] d2sum, ped;
  logic [15:0]      dout;
  logic             req, ack;
  logic [15:0]      ovf_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int got[$];
  int exp_q[$];

  prc1chan_p #(
    .ABITS(ABITS), .PBITS(PBITS), .CBITS(CBITS),
    .FBITS(FBITS), .NBITS(NBITS), .LBITS(LBITS)
  ) dut (
    .clk(clk), .reset(reset), .data(data), .cped(cped), .zthr(zthr),
    .sthr(sthr), .prescale(prescale), .winbeg(winbeg), .swinbeg(swinbeg),
    .winlen(winlen), .trigger(trigger), .num(num), .smask(smask),
    .tmask(tmask), .stmask(stmask), .d2sum(d2sum), .ped(ped), .dout(dout),
    .req(req), .ack(ack), .ovf_cnt(ovf_cnt)
  );

  always #4 clk = ~clk;

  task automatic chk(input string tag, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, expv);
    end
  endtask

  task automatic drain();
    int idle;
    idle = 0;
    got.delete();
    for (int i = 0; i < 400 && idle < 6; i++) begin
      @(negedge clk);
      if (req) begin
        got.push_back(int'(dout));
        ack  = 1'b1;
        idle = 0;
      end else begin
        ack = 1'b0;
        idle++;
      end
    end
    ack = 1'b0;
  endtask

  task automatic cmp_block(input string tag);
    chk({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk(tag, got[i], exp_q[i]);
  endtask

  // master trigger at k=0, one sample of 110 (pdata 60) at k=spike_at
  task automatic master(input logic [15:0] tw, input int spike_at);
    for (int k = 0; k < 50; k++) begin
      trigger = (k == 0) ? tw : 16'h0000;
      data    = (k == spike_at) ? 12'd110 : 12'd100;
      @(negedge clk);
    end
    trigger = 16'h0000;
    data    = 12'd100;
  endtask

  // expected master block, flat pdata 50 with 60 at index spike_at
  task automatic master_exp(input int wl, input int tw, input int spike_at);
    exp_q.delete();
    exp_q.push_back(16'hC500 | wl);
    exp_q.push_back(tw);
    for (int k = 0; k < wl; k++) exp_q.push_back((k == spike_at) ? 60 : 50);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; data = 12'd100; cped = 12'd50; zthr = 12'd5; sthr = 12'd200;
    prescale = 16'd0; winbeg = '0; swinbeg = 6'd1; winlen = 8'd8;
    trigger = 16'h0000; num = 6'd5; smask = 1'b0; tmask = 1'b0; stmask = 1'b0;
    ack = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ped", int'(ped), 0);
    chk("rst_ovf", int'(ovf_cnt), 0);
    chk("rst_req", int'(req), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_d2sum", int'(d2sum), 0);
    reset = 1'b0;

    // pedestal settles to the constant input
    repeat (40) @(negedge clk);
    chk("ped_settle", int'(ped), 100);
    chk("d2sum_flat", int'(d2sum), 0);
    data = 12'd105;
    @(negedge clk);
    chk("d2sum_pos", int'(d2sum), 5);
    smask = 1'b1;
    @(negedge clk);
    chk("d2sum_smask", int'(d2sum), 0);
    smask = 1'b0; data = 12'd95;
    @(negedge clk);
    chk("d2sum_clamp", int'(d2sum), 0);
    data = 12'd100;
    repeat (40) @(negedge clk);
    chk("ped_resettle", int'(ped), 100);

`ifdef PRC1CHAN_SELFTRIG_EN
    // large bursts must not enter the pedestal
    stmask = 1'b1;
    data = 12'd4000;
    repeat (8) @(negedge clk);
    data = 12'd100;
    repeat (40) @(negedge clk);
    chk("ped_burst_excl", int'(ped), 100);
    chk("burst_no_block", int'(req), 0);
    stmask = 1'b0;
`endif

    // master zero suppression
    winlen = 8'd8;
    master(16'h8111, -1);
    chk("zs_flat_req", int'(req), 0);
    drain();
    chk("zs_flat_words", got.size(), 0);
    master(16'h8ABC, 2);
    drain();
    master_exp(8, 16'h8ABC, 2);
    cmp_block("zs_spike");

`ifdef PRC1CHAN_SELFTRIG_EN
    // prescale 2: pulses 3, 6, 9 produce blocks
    prescale = 16'd2; winlen = 8'd4;
    for (int p = 0; p < 9; p++) begin
      data = 12'd400;
      @(negedge clk);
      data = 12'd100;
      repeat (19) @(negedge clk);
    end
    drain();
    exp_q.delete();
    for (int b = 0; b < 3; b++) begin
      exp_q.push_back(16'h8504);
      exp_q.push_back(50); exp_q.push_back(350);
      exp_q.push_back(50); exp_q.push_back(50);
    end
    cmp_block("self_prescale");

    // master trigger three cycles after strig replaces the self block
    prescale = 16'd0; winbeg = 6'd5;
    for (int k = 0; k < 40; k++) begin
      data    = (k == 0) ? 12'd400 : 12'd100;
      trigger = (k == 4) ? 16'h8123 : 16'h0000;
      @(negedge clk);
    end
    data = 12'd100; trigger = 16'h0000;
    drain();
    exp_q.delete();
    exp_q.push_back(16'hC504); exp_q.push_back(16'h8123);
    exp_q.push_back(50); exp_q.push_back(350);
    exp_q.push_back(50); exp_q.push_back(50);
    cmp_block("abort");
    begin
      int selfh;
      selfh = 0;
      foreach (got[i]) if (got[i][15:14] == 2'b10) selfh++;
      chk("abort_no_self_hdr", selfh, 0);
    end
    winbeg = '0;
`endif

    // full FIFO: 32-word blocks in a 63-word FIFO
    winlen = 8'd30;
    master(16'h8001, 0);
    chk("full_first_req", int'(req), 1);
    chk("full_first_ovf", int'(ovf_cnt), 0);
    master(16'h8002, 0);
    chk("full_drop_ovf", int'(ovf_cnt), 1);
    drain();
    master_exp(30, 16'h8001, 0);
    cmp_block("full_first");
    master(16'h8003, 0);
    chk("full_retrig_ovf", int'(ovf_cnt), 1);
    drain();
    master_exp(30, 16'h8003, 0);
    cmp_block("full_retrig");

    // reset in the middle of a master copy
    trigger = 16'h8004; data = 12'd110;
    @(negedge clk);
    trigger = 16'h0000; data = 12'd100;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_req", int'(req), 0);
    chk("midrst_ovf", int'(ovf_cnt), 0);
    chk("midrst_ped", int'(ped), 0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    winlen = 8'd4;
    master(16'h8005, 1);
    drain();
    master_exp(4, 16'h8005, 1);
    cmp_block("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
